// File: rtl/pad_framer_u8.sv
// pad_framer_u8: pulls a raw u8 image over valid/ready and emits it framed by a
// constant-valued border as a valid-gated raster with line/frame/pad flags.
// The raster walk sets the pace: interior pixels are requested only when the
// current position needs one, and pad beats are produced without any input.
module pad_framer_u8 #(
   parameter int unsigned IMG_W      = 28,
   parameter int unsigned IMG_H      = 28,
   parameter int unsigned PAD        = 2,
   parameter logic [7:0]  PAD_VALUE  = 8'd128,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       srst,
   input  logic       start,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_pixel,
   input  logic       in_last,
   output logic       out_valid,
   output logic [7:0] out_pixel,
   output logic       out_line_last,
   output logic       out_frame_last,
   output logic       out_is_pad,
   output logic       busy,
   output logic       err_len
);

   localparam int unsigned OW = IMG_W + 2 * PAD;
   localparam int unsigned OH = IMG_H + 2 * PAD;
   localparam int unsigned CW = (OW > 1) ? $clog2(OW) : 1;
   localparam int unsigned RW = (OH > 1) ? $clog2(OH) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [CW-1:0] COL_LAST    = CW'(OW - 1);
   localparam logic [RW-1:0] ROW_LAST    = RW'(OH - 1);
   localparam logic [CW-1:0] COL_IN_LAST = CW'(PAD + IMG_W - 1);
   localparam logic [RW-1:0] ROW_IN_LAST = RW'(PAD + IMG_H - 1);
   localparam logic [CW:0]   COL_PAD     = (CW + 1)'(PAD);
   localparam logic [RW:0]   ROW_PAD     = (RW + 1)'(PAD);
   localparam logic [CW:0]   COL_SPAN    = (CW + 1)'(IMG_W);
   localparam logic [RW:0]   ROW_SPAN    = (RW + 1)'(IMG_H);
   localparam logic [GW-1:0] GAP_LAST    = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [GW-1:0] gap_cnt;

   // Beat register stage (p1): one cycle behind the position / handshake.
   logic          vld_p1;
   logic [7:0]    pix_p1;
   logic          line_last_p1;
   logic          frame_last_p1;
   logic          is_pad_p1;
   logic          err_p1;

   logic [CW:0]   col_off;
   logic [RW:0]   row_off;
   logic          interior;
   logic          running;
   logic          hs;
   logic          adv;
   logic          at_col_last;
   logic          at_final;
   logic          at_in_final;

   // Offsetting by PAD makes positions left/above the interior wrap to a large
   // value, so a single unsigned compare covers both sides of the border.
   assign col_off     = {1'b0, col} - COL_PAD;
   assign row_off     = {1'b0, row} - ROW_PAD;
   assign interior    = (col_off < COL_SPAN) && (row_off < ROW_SPAN);
   assign running     = (state == RUN);
   assign in_ready    = running && interior;
   assign hs          = in_ready && in_valid;
   assign adv         = running && (!interior || in_valid);
   assign at_col_last = (col == COL_LAST);
   assign at_final    = at_col_last && (row == ROW_LAST);
   assign at_in_final = (col == COL_IN_LAST) && (row == ROW_IN_LAST);
   assign busy        = (state != IDLE);

   assign out_valid      = vld_p1;
   assign out_pixel      = pix_p1;
   assign out_line_last  = line_last_p1;
   assign out_frame_last = frame_last_p1;
   assign out_is_pad     = is_pad_p1;
   assign err_len        = err_p1;

   // Frame FSM: raster walk, registered beat outputs and the sticky length check.
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         state         <= IDLE;
         col           <= '0;
         row           <= '0;
         gap_cnt       <= '0;
         vld_p1        <= 1'b0;
         pix_p1        <= '0;
         line_last_p1  <= 1'b0;
         frame_last_p1 <= 1'b0;
         is_pad_p1     <= 1'b0;
         err_p1        <= 1'b0;
      end else begin
         vld_p1        <= adv;
         line_last_p1  <= adv && at_col_last;
         frame_last_p1 <= adv && at_final;
         is_pad_p1     <= adv && !interior;
         if (adv) begin
            pix_p1 <= interior ? in_pixel : PAD_VALUE;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  col    <= '0;
                  row    <= '0;
                  err_p1 <= 1'b0;
               end
            end
            RUN: begin
               if (hs && (in_last != at_in_final)) begin
                  err_p1 <= 1'b1;
               end
               if (adv) begin
                  if (at_col_last) begin
                     col <= '0;
                     if (at_final) begin
                        row     <= '0;
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pad_framer_u8.sv
// Bench for pad_framer_u8: a 4x3/PAD=1 instance for the main scenarios and a
// 2x2/PAD=0 instance for the borderless case. Expected beats come from a
// raster model pushed into a queue and popped as the DUT emits beats.
module tb_pad_framer_u8;

   typedef struct packed {
      logic [7:0] pix;
      logic       ll;
      logic       fl;
      logic       pad;
   } beat_t;

   logic       clk;
   logic       srst;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_pixel;
   logic       in_last;
   logic       out_valid;
   logic [7:0] out_pixel;
   logic       out_line_last;
   logic       out_frame_last;
   logic       out_is_pad;
   logic       busy;
   logic       err_len;

   logic       z_start;
   logic       z_in_valid;
   logic       z_in_ready;
   logic [7:0] z_in_pixel;
   logic       z_in_last;
   logic       z_out_valid;
   logic [7:0] z_out_pixel;
   logic       z_out_line_last;
   logic       z_out_frame_last;
   logic       z_out_is_pad;
   logic       z_busy;
   logic       z_err_len;

   beat_t exp_q[$];
   int    n_cmp;
   int    n_bad;

   int r_beats, r_pads, r_first, r_span, r_rdy, r_holes;
   int r_err_rise, r_last_hs, r_err_end, r_err_c1, r_busy_c1, r_gap_hi;

   pad_framer_u8 #(.IMG_W(4), .IMG_H(3), .PAD(1), .PAD_VALUE(8'd128), .GAP_CYCLES(4)) dut (
      .clk(clk), .srst(srst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_pixel(in_pixel), .in_last(in_last), .out_valid(out_valid), .out_pixel(out_pixel),
      .out_line_last(out_line_last), .out_frame_last(out_frame_last), .out_is_pad(out_is_pad),
      .busy(busy), .err_len(err_len)
   );

   pad_framer_u8 #(.IMG_W(2), .IMG_H(2), .PAD(0), .PAD_VALUE(8'd128), .GAP_CYCLES(4)) dut_z (
      .clk(clk), .srst(srst), .start(z_start), .in_valid(z_in_valid), .in_ready(z_in_ready),
      .in_pixel(z_in_pixel), .in_last(z_in_last), .out_valid(z_out_valid), .out_pixel(z_out_pixel),
      .out_line_last(z_out_line_last), .out_frame_last(z_out_frame_last), .out_is_pad(z_out_is_pad),
      .busy(z_busy), .err_len(z_err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Push the expected padded raster for an OWxOH frame; interior pixels are base+1, base+2, ...
   task automatic push_frame(input int ow, input int oh, input int pad, input int base);
      int k;
      beat_t b;
      k = base;
      for (int r = 0; r < oh; r++) begin
         for (int c = 0; c < ow; c++) begin
            if (r >= pad && r < oh - pad && c >= pad && c < ow - pad) begin
               k++;
               b.pix = 8'(k);
               b.pad = 1'b0;
            end else begin
               b.pix = 8'd128;
               b.pad = 1'b1;
            end
            b.ll = (c == ow - 1);
            b.fl = (c == ow - 1) && (r == oh - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   // Drive one frame on the main instance starting at the current negedge, compare
   // beats against the queue, then walk the gap. Caller is at a negedge.
   task automatic run_frame(input int stall_at, input int stall_len, input int last_at,
                            input int mid_start, input bit gap_start);
      int    src, cyc, stalled, g;
      bit    done;
      beat_t e;
      beat_t o;
      push_frame(6, 5, 1, 0);
      src = 0; cyc = 0; stalled = 0; done = 1'b0;
      r_beats = 0; r_pads = 0; r_first = -1; r_span = 0; r_rdy = 0; r_holes = 0;
      r_err_rise = -1; r_last_hs = -1; r_err_c1 = -1; r_busy_c1 = -1; r_gap_hi = -1;
      while (!done && cyc < 200) begin
         if (out_valid) begin
            if (r_first < 0) r_first = cyc;
            r_beats++;
            if (out_is_pad) r_pads++;
            o = '{pix: out_pixel, ll: out_line_last, fl: out_frame_last, pad: out_is_pad};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL beat_extra cyc=%0d got pix=%0d ll=%b fl=%b pad=%b want no beat",
                        cyc, o.pix, o.ll, o.fl, o.pad);
            end else begin
               e = exp_q.pop_front();
               if (o !== e) begin
                  n_bad++;
                  $display("FAIL beat%0d got pix=%0d ll=%b fl=%b pad=%b want pix=%0d ll=%b fl=%b pad=%b",
                           r_beats, o.pix, o.ll, o.fl, o.pad, e.pix, e.ll, e.fl, e.pad);
               end
            end
            if (out_frame_last) begin
               done = 1'b1;
               r_span = cyc - r_first + 1;
            end
         end else if (r_first >= 0) begin
            r_holes++;
         end
         if (cyc == 1) begin
            r_err_c1  = int'(err_len);
            r_busy_c1 = int'(busy);
         end
         if (cyc >= 1 && err_len && r_err_rise < 0) r_err_rise = cyc;
         if (in_ready) r_rdy++;
         if (!done) begin
            start = (cyc == 0) || (cyc == mid_start);
            if (in_ready && src == stall_at && stalled < stall_len) begin
               in_valid = 1'b0;
               stalled++;
            end else if (in_ready) begin
               in_valid = 1'b1;
            end else begin
               in_valid = 1'($urandom_range(0, 1));
            end
            in_pixel = 8'(src + 1);
            in_last  = (src == last_at);
            if (in_valid && in_ready) begin
               if (in_last) r_last_hs = cyc;
               src++;
            end
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      r_err_end = int'(err_len);
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL frame_timeout got no frame_last in %0d cycles want frame_last", cyc);
      end else begin
         g = 0;
         start = gap_start;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) g++;
            else break;
         end
         r_gap_hi = g;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL beats_missing got %0d left over want 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset_state();
      n_cmp++;
      if ({out_valid, out_pixel, out_line_last, out_frame_last, out_is_pad, busy, err_len, in_ready} !== 14'd0) begin
         n_bad++;
         $display("FAIL reset_outputs got v=%b p=%0d ll=%b fl=%b pad=%b busy=%b err=%b rdy=%b want all 0",
                  out_valid, out_pixel, out_line_last, out_frame_last, out_is_pad, busy, err_len, in_ready);
      end
      n_cmp++;
      if ({z_out_valid, z_out_pixel, z_busy, z_err_len, z_in_ready} !== 12'd0) begin
         n_bad++;
         $display("FAIL reset_outputs_pad0 got v=%b p=%0d busy=%b err=%b rdy=%b want all 0",
                  z_out_valid, z_out_pixel, z_busy, z_err_len, z_in_ready);
      end
   endtask

   task automatic test_basic_frame();
      run_frame(-1, 0, 11, -1, 1'b0);
      n_cmp++; if (r_beats !== 30) begin n_bad++; $display("FAIL basic_beats got %0d want 30", r_beats); end
      n_cmp++; if (r_pads !== 18) begin n_bad++; $display("FAIL basic_pads got %0d want 18", r_pads); end
      n_cmp++; if (r_first !== 2) begin n_bad++; $display("FAIL basic_latency got %0d want 2", r_first); end
      n_cmp++; if (r_rdy !== 12) begin n_bad++; $display("FAIL basic_ready_cycles got %0d want 12", r_rdy); end
      n_cmp++; if (r_span !== 30) begin n_bad++; $display("FAIL basic_span got %0d want 30", r_span); end
      n_cmp++; if (r_err_end !== 0) begin n_bad++; $display("FAIL basic_err got %0d want 0", r_err_end); end
      n_cmp++; if (r_gap_hi !== 3) begin n_bad++; $display("FAIL basic_gap got %0d want 3", r_gap_hi); end
   endtask

   task automatic test_stall();
      repeat (2) @(negedge clk);
      run_frame(5, 3, 11, -1, 1'b0);
      n_cmp++; if (r_holes !== 3) begin n_bad++; $display("FAIL stall_holes got %0d want 3", r_holes); end
      n_cmp++; if (r_span !== 33) begin n_bad++; $display("FAIL stall_span got %0d want 33", r_span); end
      n_cmp++; if (r_rdy !== 15) begin n_bad++; $display("FAIL stall_ready_cycles got %0d want 15", r_rdy); end
      n_cmp++; if (r_pads !== 18) begin n_bad++; $display("FAIL stall_pads got %0d want 18", r_pads); end
   endtask

   task automatic test_len_early();
      repeat (2) @(negedge clk);
      run_frame(-1, 0, 9, -1, 1'b0);
      n_cmp++;
      if (r_last_hs < 0 || r_err_rise !== r_last_hs + 1) begin
         n_bad++;
         $display("FAIL early_err_rise got %0d want %0d", r_err_rise, r_last_hs + 1);
      end
      n_cmp++; if (r_beats !== 30) begin n_bad++; $display("FAIL early_beats got %0d want 30", r_beats); end
      n_cmp++; if (r_err_end !== 1) begin n_bad++; $display("FAIL early_err_sticky got %0d want 1", r_err_end); end
   endtask

   task automatic test_err_clear();
      run_frame(-1, 0, 11, -1, 1'b0);
      n_cmp++; if (r_err_c1 !== 0) begin n_bad++; $display("FAIL clear_err_on_start got %0d want 0", r_err_c1); end
      n_cmp++; if (r_err_end !== 0) begin n_bad++; $display("FAIL clear_err_end got %0d want 0", r_err_end); end
   endtask

   task automatic test_len_missing();
      run_frame(-1, 0, -1, -1, 1'b0);
      n_cmp++; if (r_err_end !== 1) begin n_bad++; $display("FAIL missing_last_err got %0d want 1", r_err_end); end
      n_cmp++; if (r_beats !== 30) begin n_bad++; $display("FAIL missing_last_beats got %0d want 30", r_beats); end
   endtask

   task automatic test_start_ignored();
      repeat (2) @(negedge clk);
      run_frame(-1, 0, 11, 10, 1'b1);
      n_cmp++; if (r_span !== 30) begin n_bad++; $display("FAIL midstart_span got %0d want 30", r_span); end
      n_cmp++; if (r_gap_hi !== 3) begin n_bad++; $display("FAIL gapstart_gap got %0d want 3", r_gap_hi); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL gap_end_idle got busy=%b want 0", busy); end
      run_frame(-1, 0, 11, -1, 1'b0);
      n_cmp++; if (r_busy_c1 !== 1) begin n_bad++; $display("FAIL idle_start_busy got %0d want 1", r_busy_c1); end
      n_cmp++; if (r_beats !== 30) begin n_bad++; $display("FAIL idle_start_beats got %0d want 30", r_beats); end
   endtask

   task automatic test_pad_zero();
      int    src, nb, first;
      bit    done;
      beat_t e;
      beat_t o;
      push_frame(2, 2, 0, 20);
      src = 0; nb = 0; first = -1; done = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         if (z_out_valid) begin
            if (first < 0) first = cyc;
            nb++;
            o = '{pix: z_out_pixel, ll: z_out_line_last, fl: z_out_frame_last, pad: z_out_is_pad};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL pad0_extra got pix=%0d want no beat", o.pix);
            end else begin
               e = exp_q.pop_front();
               if (o !== e) begin
                  n_bad++;
                  $display("FAIL pad0_beat%0d got pix=%0d ll=%b fl=%b pad=%b want pix=%0d ll=%b fl=%b pad=%b",
                           nb, o.pix, o.ll, o.fl, o.pad, e.pix, e.ll, e.fl, e.pad);
               end
            end
            if (z_out_frame_last) done = 1'b1;
         end
         if (!done) begin
            z_start    = (cyc == 0);
            z_in_valid = 1'b1;
            z_in_pixel = 8'(21 + src);
            z_in_last  = (src == 3);
            if (z_in_ready) src++;
            @(negedge clk);
         end
      end
      z_start = 1'b0; z_in_valid = 1'b0; z_in_last = 1'b0;
      n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL pad0_beats got %0d want 4", nb); end
      n_cmp++; if (first !== 2) begin n_bad++; $display("FAIL pad0_latency got %0d want 2", first); end
      n_cmp++; if (z_err_len !== 1'b0) begin n_bad++; $display("FAIL pad0_err got %b want 0", z_err_len); end
      exp_q.delete();
      repeat (6) @(negedge clk);
   endtask

   task automatic test_async_reset();
      int stray;
      start = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid got %b want 1", out_valid); end
      @(posedge clk);
      #2 srst = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, out_pixel, out_line_last, out_frame_last, out_is_pad, busy, err_len, in_ready} !== 14'd0) begin
         n_bad++;
         $display("FAIL async_reset got v=%b p=%0d ll=%b fl=%b pad=%b busy=%b err=%b rdy=%b want all 0",
                  out_valid, out_pixel, out_line_last, out_frame_last, out_is_pad, busy, err_len, in_ready);
      end
      @(negedge clk);
      srst = 1'b0;
      stray = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid || busy) stray++;
      end
      in_valid = 1'b0;
      n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL no_resume got %0d active cycles want 0", stray); end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      srst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = 8'd0; in_last = 1'b0;
      z_start = 1'b0; z_in_valid = 1'b0; z_in_pixel = 8'd0; z_in_last = 1'b0;
      repeat (3) @(negedge clk);
      test_reset_state();
      srst = 1'b0;
      repeat (2) @(negedge clk);
      test_basic_frame();
      test_stall();
      test_len_early();
      test_err_clear();
      test_len_missing();
      test_start_ignored();
      test_pad_zero();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
